// File: rtl/noc_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkt_pkg
// Description : Single-flit NoC packet field positions and buffer state
//               encoding, shared by the packetizer and depacketizer.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkt_pkg;

    localparam int SEQ_WIDTH = 4;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Payload field width left after the control, VC and address fields.
    function automatic int data_idl_width(input int width_pkt, input int vc_w, input int addr_w);
        return width_pkt - 6 - 2 * vc_w - addr_w;
    endfunction

    function automatic int pkt_valid_pos(input int width_pkt);
        return width_pkt - 1;
    endfunction

    function automatic int pkt_head_pos(input int width_pkt);
        return width_pkt - 2;
    endfunction

    function automatic int pkt_tail_pos(input int width_pkt);
        return width_pkt - 3;
    endfunction

    function automatic int pkt_vc_msb(input int width_pkt);
        return width_pkt - 4;
    endfunction

    function automatic int pkt_dest_msb(input int width_pkt, input int vc_w);
        return width_pkt - 4 - vc_w;
    endfunction

    function automatic int pkt_data_msb(input int width_pkt, input int vc_w, input int addr_w);
        return data_idl_width(width_pkt, vc_w, addr_w) - 1;
    endfunction

endpackage : noc_pkt_pkg
`default_nettype wire

// File: rtl/noc_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : noc_skid_buffer
// Description : Generic 2-entry valid/ready register slice; ready and valid
//               are both registered so neither path is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_skid_buffer
    import noc_pkt_pkg::*;
#(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    buf_state_e       r_state;
    buf_state_e       w_state_next;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic             r_ready;
    logic             r_valid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_head;
    logic             w_load_skid;
    logic             w_promote;

    assign w_in_fire  = i_valid & r_ready;
    assign w_out_fire = r_valid & i_ready;

    always_comb begin
        w_state_next = r_state;
        w_load_head  = 1'b0;
        w_load_skid  = 1'b0;
        w_promote    = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_in_fire) begin
                    w_state_next = BUF_ONE;
                    w_load_head  = 1'b1;
                end
            end
            BUF_ONE: begin
                case ({w_in_fire, w_out_fire})
                    2'b10: begin
                        w_state_next = BUF_FULL;
                        w_load_skid  = 1'b1;
                    end
                    2'b01: w_state_next = BUF_EMPTY;
                    // Head leaves while the new word takes its place.
                    2'b11: w_load_head = 1'b1;
                    default: w_state_next = BUF_ONE;
                endcase
            end
            BUF_FULL: begin
                if (w_out_fire) begin
                    w_state_next = BUF_ONE;
                    w_promote    = 1'b1;
                end
            end
            default: w_state_next = BUF_EMPTY;
        endcase
    end

    // ready/valid are precomputed from the next state so they leave a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != BUF_FULL);
            r_valid <= (w_state_next != BUF_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= i_data;
            end else if (w_promote) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_head;

endmodule : noc_skid_buffer
`default_nettype wire

// File: rtl/packetizer_1_sub.sv
`default_nettype none
// ============================================================================
// Module      : packetizer_1_sub
// Description : Wraps each data word into a single-flit NoC packet behind a
//               2-entry skid buffer. Option PACKETIZER_SEQNUM_EN adds a 4-bit
//               sequence number in the low pad bits.
// Revision    : 1.0 - initial release
// ============================================================================
module packetizer_1_sub
    import noc_pkt_pkg::*;
#(
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_DATA-1:0]       data_in,
    input  logic [ADDRESS_WIDTH-1:0]    dest_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_PKT-1:0]        data_out,
    output logic                        valid_out,
    input  logic                        ready_in
);

    localparam int WIDTH_DATA_IDL = data_idl_width(WIDTH_PKT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH);
    localparam int c_valid_pos    = pkt_valid_pos(WIDTH_PKT);
    localparam int c_head_pos     = pkt_head_pos(WIDTH_PKT);
    localparam int c_tail_pos     = pkt_tail_pos(WIDTH_PKT);
    localparam int c_vc_msb       = pkt_vc_msb(WIDTH_PKT);
    localparam int c_dest_msb     = pkt_dest_msb(WIDTH_PKT, VC_ADDRESS_WIDTH);
    localparam int c_data_msb     = pkt_data_msb(WIDTH_PKT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH);

    generate
        if (WIDTH_DATA > WIDTH_DATA_IDL) begin : g_width_check
            $error("packetizer_1_sub: WIDTH_DATA exceeds packet payload field");
        end
    endgenerate

    logic [WIDTH_PKT-1:0] w_pkt;

`ifdef PACKETIZER_SEQNUM_EN
    logic                 w_in_fire;
    logic [SEQ_WIDTH-1:0] r_seq;

    generate
        if (WIDTH_DATA_IDL - WIDTH_DATA < SEQ_WIDTH) begin : g_pad_check
            $error("packetizer_1_sub: no room for sequence number in pad bits");
        end
    endgenerate

    assign w_in_fire = valid_in & ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq <= '0;
        end else if (w_in_fire) begin
            r_seq <= r_seq + 1'b1;
        end
    end
`endif

    always_comb begin
        w_pkt                                      = '0;
        w_pkt[c_valid_pos]                         = 1'b1;
        w_pkt[c_head_pos]                          = 1'b1;
        w_pkt[c_tail_pos]                          = 1'b1;
        w_pkt[c_vc_msb -: VC_ADDRESS_WIDTH]        = vc_in;
        w_pkt[c_dest_msb -: ADDRESS_WIDTH]         = dest_in;
        w_pkt[c_data_msb -: WIDTH_DATA]            = data_in;
`ifdef PACKETIZER_SEQNUM_EN
        // Sequence number is captured alongside the word it labels.
        w_pkt[SEQ_WIDTH-1:0]                       = r_seq;
`endif
    end

    noc_skid_buffer #(
        .WIDTH (WIDTH_PKT)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_pkt),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .o_data  (data_out),
        .o_valid (valid_out),
        .i_ready (ready_in)
    );

endmodule : packetizer_1_sub
`default_nettype wire

// File: tb/tb_packetizer_1_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_packetizer_1_sub
// Description : Self-checking bench for packetizer_1_sub with a packet
//               scoreboard; follows PACKETIZER_SEQNUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packetizer_1_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] data_in = '0;
    logic [3:0]  dest_in = '0;
    logic        vc_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic [35:0] data_out;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    logic [35:0] sb[$];
    logic [3:0]  m_seq = '0;
    logic        prev_hold = 1'b0;
    logic [35:0] prev_data = '0;

    packetizer_1_sub #(
        .WIDTH_PKT        (36),
        .WIDTH_DATA       (12),
        .VC_ADDRESS_WIDTH (1),
        .ADDRESS_WIDTH    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .dest_in   (dest_in),
        .vc_in     (vc_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] mk_pkt(input logic [11:0] d, input logic [3:0] a,
                                           input logic v, input logic [3:0] s);
        return {3'b111, v, a, 4'h0, d, 8'h00, s};
    endfunction

    // Scoreboard: push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        logic [35:0] exp;
        if (rst) begin
            sb.delete();
            m_seq     = '0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                n_cmp++;
                if (valid_out !== 1'b1 || data_out !== prev_data) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                             valid_out, data_out, prev_data);
                end
            end
            if (valid_out && ready_in) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got packet %h, required none", data_out);
                end else begin
                    exp = sb.pop_front();
                    n_pop++;
                    if (data_out !== exp) begin
                        n_err++;
                        $display("FAIL sb_packet: got %h, required %h", data_out, exp);
                    end
                end
            end
            prev_hold = valid_out && !ready_in;
            prev_data = data_out;
            if (valid_in && ready_out) begin
`ifdef PACKETIZER_SEQNUM_EN
                sb.push_back(mk_pkt(data_in, dest_in, vc_in, m_seq));
`else
                sb.push_back(mk_pkt(data_in, dest_in, vc_in, 4'h0));
`endif
                m_seq = m_seq + 4'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a word and returns #1 after the edge that accepted it; valid_in stays high.
    task automatic send(input logic [11:0] d, input logic [3:0] a, input logic v, input int bound);
        int   n;
        logic fire;
        n        = 0;
        fire     = 1'b0;
        data_in  = d;
        dest_in  = a;
        vc_in    = v;
        valid_in = 1'b1;
        while (!fire && n < bound) begin
            @(negedge clk);
            fire = ready_out;
            tick();
            n++;
        end
        if (!fire) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: word %h not accepted in %0d cycles", d, bound);
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d packets left, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (valid_out !== 1'b0 || ready_out !== 1'b0 || data_out !== 36'h0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h, required 0 0 0",
                     valid_out, ready_out, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready=%b valid=%b, required 1 0", ready_out, valid_out);
        end
    endtask

    task automatic test_single();
        int p0;
        p0       = n_pop;
        ready_in = 1'b1;
        send(12'hABC, 4'h5, 1'b1, 10);
        n_cmp++;
        if (valid_out !== 1'b1 || data_out !== 36'hF50ABC000) begin
            n_err++;
            $display("FAIL single_pkt: valid=%b data=%h, required 1 F50ABC000", valid_out, data_out);
        end
        valid_in = 1'b0;
        tick();
        n_cmp++;
        if (valid_out !== 1'b0 || n_pop - p0 != 1) begin
            n_err++;
            $display("FAIL single_after: valid=%b pops=%0d, required 0 1", valid_out, n_pop - p0);
        end
    endtask

    task automatic test_stream();
        int p0;
        p0       = n_pop;
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(12'(i * 12'h123 + 1), 4'(i), 1'(i), 2);
            n_cmp++;
            if (ready_out !== 1'b1 || valid_out !== 1'b1) begin
                n_err++;
                $display("FAIL stream_flow[%0d]: ready=%b valid=%b, required 1 1", i, ready_out, valid_out);
            end
        end
        drain(10);
        n_cmp++;
        if (n_pop - p0 != 8) begin
            n_err++;
            $display("FAIL stream_count: got %0d packets, required 8", n_pop - p0);
        end
    endtask

    task automatic test_backpressure();
        int          p0;
        logic [35:0] exp;
        p0       = n_pop;
        ready_in = 1'b0;
        send(12'h111, 4'h1, 1'b0, 4);
        send(12'h222, 4'h2, 1'b1, 4);
        n_cmp++;
        if (ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full_ready: got %b, required 0", ready_out);
        end
        data_in = 12'h333;
        dest_in = 4'h3;
        vc_in   = 1'b0;
        repeat (3) tick();
        exp = mk_pkt(12'h111, 4'h1, 1'b0, 4'h0);
        n_cmp++;
        if (ready_out !== 1'b0 || valid_out !== 1'b1 || data_out[35:4] !== exp[35:4]) begin
            n_err++;
            $display("FAIL bp_hold: ready=%b valid=%b data=%h, required 0 1 %h",
                     ready_out, valid_out, data_out, exp);
        end
        ready_in = 1'b1;
        send(12'h333, 4'h3, 1'b0, 6);
        drain(10);
        n_cmp++;
        if (n_pop - p0 != 3) begin
            n_err++;
            $display("FAIL bp_count: got %0d packets, required 3", n_pop - p0);
        end
    endtask

    task automatic test_random();
        int   sent;
        int   cyc;
        int   p0;
        logic fire;
        sent     = 0;
        cyc      = 0;
        p0       = n_pop;
        valid_in = 1'b0;
        while (sent < 3000 && cyc < 40000) begin
            if (!valid_in && $urandom_range(0, 3) != 0) begin
                valid_in = 1'b1;
                data_in  = 12'($urandom);
                dest_in  = 4'($urandom);
                vc_in    = 1'($urandom);
            end
            ready_in = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fire = valid_in && ready_out;
            tick();
            cyc++;
            if (fire) begin
                sent++;
                valid_in = 1'b0;
            end
        end
        drain(10);
        n_cmp++;
        if (sent != 3000 || n_pop - p0 != 3000) begin
            n_err++;
            $display("FAIL random_count: sent=%0d received=%0d, required 3000 3000", sent, n_pop - p0);
        end
    endtask

    task automatic test_reset_full();
        ready_in = 1'b0;
        send(12'h5A5, 4'h9, 1'b1, 4);
        send(12'hA5A, 4'hA, 1'b0, 4);
        valid_in = 1'b0;
        n_cmp++;
        if (ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL rstfull_ready: got %b, required 0", ready_out);
        end
        rst = 1'b1;
        #2;
        n_cmp++;
        if (valid_out !== 1'b0 || ready_out !== 1'b0 || data_out !== 36'h0) begin
            n_err++;
            $display("FAIL rstfull_async: valid=%b ready=%b data=%h, required 0 0 0",
                     valid_out, ready_out, data_out);
        end
        repeat (2) tick();
        @(negedge clk);
        rst      = 1'b0;
        ready_in = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL rstfull_after: valid=%b ready=%b, required 0 1", valid_out, ready_out);
        end
    endtask

    task automatic test_seqnum();
        logic [3:0] e;
        ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(12'(i + 12'h700), 4'(i), 1'(i), 2);
`ifdef PACKETIZER_SEQNUM_EN
            e = 4'(i);
`else
            e = 4'h0;
`endif
            n_cmp++;
            if (valid_out !== 1'b1 || data_out[3:0] !== e) begin
                n_err++;
                $display("FAIL seqnum[%0d]: valid=%b pad=%h, required 1 %h", i, valid_out, data_out[3:0], e);
            end
        end
        drain(10);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_full();
        test_seqnum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_packetizer_1_sub
`default_nettype wire
